// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave endpoint and future bus monitors.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } slv_state_e;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h2A;

    // Register pointer advance; wraps 8'hFF to 8'h00 silently.
    function automatic logic [7:0] ptr_inc(input logic [7:0] ptr);
        return ptr + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_slave_regif_if.sv
// Bus pins plus register-file strobe interface of the I2C slave endpoint.
interface i2c_slave_regif_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output scl_in, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with single-clk edge and START/STOP pulses.
// Pulses and sda_lvl appear SYNC_STAGES+1 clks after the pin edge; no backpressure.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic scl_hist_q, scl_hist_d;
    logic sda_hist_q, sda_hist_d;
    logic scl_rise_q, scl_rise_d;
    logic scl_fall_q, scl_fall_d;
    logic start_q, start_d;
    logic stop_q, stop_d;
    logic scl_s, sda_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
        scl_s      = scl_sync_q[SYNC_STAGES-1];
        sda_s      = sda_sync_q[SYNC_STAGES-1];
        scl_hist_d = scl_s;
        sda_hist_d = sda_s;
        scl_rise_d = scl_s & ~scl_hist_q;
        scl_fall_d = ~scl_s & scl_hist_q;
        // SDA may only change with SCL held high across both samples.
        start_d    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
        stop_d     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    end

    // Lines reset to the idle-high level so release of reset creates no edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign sda_lvl   = sda_hist_q;
    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: rtl/i2c_slave_regif.sv
// Oversampled I2C slave: address match, 8-bit register pointer, single-clk reg_we/reg_re strobes.
// Acts one clk after a line event is detected; the register file must accept every strobe.
module i2c_slave_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    i2c_slave_regif_if.slave bus
);

    logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .sda_lvl   (sda_lvl),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    slv_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_re_q, reg_re_d;
    logic       sda_oe_q, sda_oe_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_byte;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        rx_byte     = {shift_q[6:0], sda_lvl};

        // Pointer advances the clk after a write strobe so the strobe sees the old pointer.
        if (reg_we_q) begin
            reg_addr_d = ptr_inc(reg_addr_q);
        end
        // Read strobe: reg_rdata is consumed now, MSB goes onto the bus.
        if (reg_re_q) begin
            shift_d    = bus.reg_rdata;
            reg_addr_d = ptr_inc(reg_addr_q);
            sda_oe_d   = ~bus.reg_rdata[7];
        end

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    // bit_cnt==8 marks a complete byte awaiting the ACK slot.
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == SLAVE_ADDR) begin
                                    busy_d = 1'b1;
                                    rw_d   = rx_byte[0];
                                end else begin
                                    state_d   = ST_IDLE;
                                    bit_cnt_d = 4'd0;
                                end
                            end else if (state_q == ST_PTR) begin
                                reg_addr_d = rx_byte;
                            end else begin
                                reg_we_d    = 1'b1;
                                reg_wdata_d = rx_byte;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_ADDR) begin
                            state_d = ST_ADDR_ACK;
                        end else if (state_q == ST_PTR) begin
                            state_d = ST_PTR_ACK;
                        end else begin
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        if (rw_q == RW_READ) begin
                            reg_re_d = 1'b1;
                            state_d  = ST_RDATA;
                        end else begin
                            state_d = ST_PTR;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RDATA_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == NACK) begin
                            state_d   = ST_IDLE;
                            busy_d    = 1'b0;
                            bit_cnt_d = 4'd0;
                        end else begin
                            bit_cnt_d = 4'd8;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        reg_re_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            rw_q        <= RW_WRITE;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.reg_re    = reg_re_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench: bit-banged I2C master, register-file model and strobe logs.
module tb_i2c_slave_regif;

    localparam int Q  = 6;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] we_log [64];
    logic [7:0]  re_log [64];
    int we_cnt = 0;
    int re_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;

    i2c_slave_regif_if bif ();

    assign bif.scl_in    = scl_m;
    assign bif.sda_in    = sda_m & ~bif.sda_oe;
    assign bif.reg_rdata = mem[bif.reg_addr];

    i2c_slave_regif #(
        .SLAVE_ADDR  (7'h2A),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bif.reg_we) begin
            if (we_cnt < 64) we_log[we_cnt] = {bif.reg_addr, bif.reg_wdata};
            we_cnt = we_cnt + 1;
        end
        if (bif.reg_re) begin
            if (re_cnt < 64) re_log[re_cnt] = bif.reg_addr;
            re_cnt = re_cnt + 1;
        end
        if (bif.sda_oe) oe_cnt = oe_cnt + 1;
        if (bif.busy) busy_cnt = busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = bif.sda_in;
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            b[i] = bt;
        end
        write_bit(ack);
    endtask

    logic       ack;
    logic [7:0] rd;
    int we0, re0, oe0, busy0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h05] = 8'h96;
        mem[8'h06] = 8'h41;
        mem[8'h20] = 8'h3C;

        tick(4);
        chk("rst_sda_oe", bif.sda_oe, 1'b0);
        chk("rst_reg_we", bif.reg_we, 1'b0);
        chk("rst_reg_re", bif.reg_re, 1'b0);
        chk("rst_busy", bif.busy, 1'b0);
        chk("rst_reg_addr", bif.reg_addr, 8'h00);
        chk("rst_reg_wdata", bif.reg_wdata, 8'h00);
        reset_n = 1'b1;
        tick(4);

        // Write 0x2A/W, pointer 0x10, data A5 3C
        we0 = we_cnt;
        i2c_start();
        write_byte(8'h54, ack); chk("t1_ack_addr", ack, 1'b0);
        write_byte(8'h10, ack); chk("t1_ack_ptr", ack, 1'b0);
        write_byte(8'hA5, ack); chk("t1_ack_d0", ack, 1'b0);
        write_byte(8'h3C, ack); chk("t1_ack_d1", ack, 1'b0);
        chk("t1_busy_before_stop", bif.busy, 1'b1);
        i2c_stop();
        chk("t1_busy_after_stop", bif.busy, 1'b0);
        chk("t1_we_count", we_cnt - we0, 2);
        chk("t1_we0", we_log[we0], 16'h10A5);
        chk("t1_we1", we_log[we0 + 1], 16'h113C);
        chk("t1_final_ptr", bif.reg_addr, 8'h12);

        // Non-matching address 0x2B
        we0 = we_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
        i2c_start();
        write_byte(8'h56, ack); chk("t2_nack", ack, 1'b1);
        i2c_stop();
        chk("t2_no_oe", oe_cnt - oe0, 0);
        chk("t2_no_we", we_cnt - we0, 0);
        chk("t2_no_busy", busy_cnt - busy0, 0);

        // Pointer 0x05, repeated START, read two bytes
        re0 = re_cnt;
        i2c_start();
        write_byte(8'h54, ack); chk("t3_ack_addr_w", ack, 1'b0);
        write_byte(8'h05, ack); chk("t3_ack_ptr", ack, 1'b0);
        i2c_start();
        write_byte(8'h55, ack); chk("t3_ack_addr_r", ack, 1'b0);
        read_byte(rd, 1'b0); chk("t3_rd0", rd, 8'h96);
        read_byte(rd, 1'b1); chk("t3_rd1", rd, 8'h41);
        chk("t3_idle_busy", bif.busy, 1'b0);
        chk("t3_idle_oe", bif.sda_oe, 1'b0);
        chk("t3_re_count", re_cnt - re0, 2);
        chk("t3_re0_addr", re_log[re0], 8'h05);
        chk("t3_re1_addr", re_log[re0 + 1], 8'h06);
        i2c_stop();
        chk("t3_final_ptr", bif.reg_addr, 8'h07);

        // Pointer wrap from 0xFF
        we0 = we_cnt;
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack); chk("t4_ack_d0", ack, 1'b0);
        write_byte(8'h22, ack); chk("t4_ack_d1", ack, 1'b0);
        i2c_stop();
        chk("t4_we_count", we_cnt - we0, 2);
        chk("t4_we0", we_log[we0], 16'hFF11);
        chk("t4_we1", we_log[we0 + 1], 16'h0022);
        chk("t4_final_ptr", bif.reg_addr, 8'h01);

        // STOP after four data bits
        we0 = we_cnt;
        i2c_start();
        write_byte(8'h54, ack);
        write_byte(8'h20, ack);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        chk("t5_busy_mid_byte", bif.busy, 1'b1);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(SS + 2);
        chk("t5_busy_after_stop", bif.busy, 1'b0);
        chk("t5_oe_after_stop", bif.sda_oe, 1'b0);
        chk("t5_no_we", we_cnt - we0, 0);
        chk("t5_ptr_kept", bif.reg_addr, 8'h20);
        tick(Q);

        // Reset while driving read data, then a fresh transaction
        i2c_start();
        write_byte(8'h55, ack); chk("t6_ack_addr_r", ack, 1'b0);
        tick(4);
        chk("t6_oe_driving", bif.sda_oe, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_oe_async", bif.sda_oe, 1'b0);
        chk("t6_busy_async", bif.busy, 1'b0);
        chk("t6_ptr_async", bif.reg_addr, 8'h00);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(3);
        i2c_start();
        write_byte(8'h54, ack); chk("t6_ack_after_rst", ack, 1'b0);
        chk("t6_busy_after_rst", bif.busy, 1'b1);
        chk("t6_ptr_after_rst", bif.reg_addr, 8'h00);
        i2c_stop();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
